// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: opcodes, instruction
// field positions and the operand-fetch stall FSM encoding.
package cpu_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVHI = 4'd6;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JN   = 4'd10;
  localparam logic [3:0] OP_CALL = 4'd12;

  localparam int unsigned OPC_LSB   = 0;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned IMM_BIT   = 4;
  localparam int unsigned RX_LSB    = 5;
  localparam int unsigned RY_LSB    = 8;
  localparam int unsigned IMM8_LSB  = 8;
  localparam int unsigned IMM11_LSB = 5;

  typedef enum logic {
    S_RUN,
    S_STALL
  } stall_state_t;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux: the lowest-index valid source whose destination
// matches sel supplies the operand; otherwise the register file does.
module fwd_select #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         sel,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_reg,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         data,
  output logic                      hit,
  output logic                      pending
);

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    data    = rf_data;
    hit     = 1'b0;
    pending = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (fwd_valid[NUM_FWD-1-k] &&
          fwd_reg[(NUM_FWD-1-k)*REG_AW +: REG_AW] == sel) begin
        data    = fwd_data[(NUM_FWD-1-k)*DATA_W +: DATA_W];
        hit     = 1'b1;
        pending = fwd_pending[NUM_FWD-1-k];
      end
    end
  end

endmodule

// File: rtl/stage_operand_fetch.sv
// Operand-fetch stage: decode, forwarded operand resolution, load-use
// interlock, ALU operand build, memory request and registered handoff.
module stage_operand_fetch #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_ir,
  input  logic [DATA_W-1:0]         in_pc_plus_2,
  output logic [REG_AW-1:0]         rf_sel_A,
  output logic [REG_AW-1:0]         rf_sel_B,
  input  logic [DATA_W-1:0]         rf_A,
  input  logic [DATA_W-1:0]         rf_B,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_reg,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_ir,
  output logic [DATA_W-1:0]         out_op_a,
  output logic [DATA_W-1:0]         out_op_b,
  output logic [DATA_W-1:0]         out_rx,
  output logic [DATA_W-1:0]         ldst_addr,
  output logic                      ldst_rd,
  output logic                      ldst_wr,
  output logic [DATA_W-1:0]         ldst_wrdata,
  output logic [STALL_CNT_W-1:0]    stall_count
);

  import cpu_pkg::*;

  logic [OPC_W-1:0]  op;
  logic              imm;
  logic [DATA_W-1:0] rx, ry, op_a, op_b, sext8, sext11;
  logic              rx_hit, ry_hit, rx_pend, ry_pend;
  logic              reads_rx, reads_ry, is_jump, is_mem, hazard, advance, fire;
  stall_state_t      state, state_next;

  assign op       = in_ir[OPC_LSB +: OPC_W];
  assign imm      = in_ir[IMM_BIT];
  assign rf_sel_A = in_ir[RX_LSB +: REG_AW];
  assign rf_sel_B = in_ir[RY_LSB +: REG_AW];
  assign sext8    = DATA_W'($signed(in_ir[IMM8_LSB +: 8]));
  assign sext11   = DATA_W'($signed(in_ir[IMM11_LSB +: 11]));

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rx (
    .sel(rf_sel_A), .rf_data(rf_A), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_pending(fwd_pending), .fwd_data(fwd_data),
    .data(rx), .hit(rx_hit), .pending(rx_pend)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_ry (
    .sel(rf_sel_B), .rf_data(rf_B), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_pending(fwd_pending), .fwd_data(fwd_data),
    .data(ry), .hit(ry_hit), .pending(ry_pend)
  );

  assign is_jump  = (op == OP_J) || (op == OP_JZ) || (op == OP_JN);
  assign is_mem   = (op == OP_LD) || (op == OP_ST);
  assign reads_rx = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
                    (op == OP_MVHI) || (op == OP_ST) || (is_jump && !imm);
  assign reads_ry = (!imm && ((op == OP_MV) || (op == OP_ADD) ||
                              (op == OP_SUB) || (op == OP_CMP))) || is_mem;
  assign hazard   = (reads_rx && rx_hit && rx_pend) || (reads_ry && ry_hit && ry_pend);

  assign advance  = !out_valid || out_ready;
  assign in_ready = !hazard && advance && !flush;
  assign fire     = in_valid && in_ready;

  assign ldst_rd     = fire && !reset && (op == OP_LD);
  assign ldst_wr     = fire && !reset && (op == OP_ST);
  assign ldst_addr   = is_mem ? {ry[DATA_W-1:1], 1'b0} : '0;
  assign ldst_wrdata = rx;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (op)
      OP_MV:                op_b = imm ? sext8 : ry;
      OP_ADD, OP_SUB, OP_CMP: begin
        op_a = rx;
        op_b = imm ? sext8 : ry;
      end
      OP_MVHI: begin
        op_a = rx & DATA_W'(8'hFF);
        op_b = DATA_W'(in_ir[IMM8_LSB +: 8]) << 8;
      end
      OP_LD, OP_ST:         op_b = ry;
      OP_J, OP_JZ, OP_JN: begin
        op_a = imm ? in_pc_plus_2 : rx;
        op_b = imm ? (sext11 << 1) : '0;
      end
      OP_CALL:              op_b = in_pc_plus_2;
      default: ;
    endcase
  end

  // A stall persists while the hazard does, even if fetch drops in_valid.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (in_valid && hazard && !flush) state_next = S_STALL;
      S_STALL: if (!hazard || flush)             state_next = S_RUN;
      default:                                   state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      stall_count <= '0;
      out_valid   <= 1'b0;
      out_ir      <= '0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_rx      <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_STALL && stall_count != '1)
        stall_count <= stall_count + STALL_CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire) begin
        out_valid <= 1'b1;
        out_ir    <= in_ir;
        out_op_a  <= op_a;
        out_op_b  <= op_b;
        out_rx    <= rx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_operand_fetch.sv
// Directed bench for stage_operand_fetch with a cycle-level reference model
// and hand-computed expectations for the key scenarios.
module tb_stage_operand_fetch;

  localparam int NF = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic        ldst_rd, ldst_wr;
  logic [15:0] in_ir, in_pc_plus_2, rf_A, rf_B;
  logic [2:0]  rf_sel_A, rf_sel_B;
  logic [NF-1:0]    fwd_valid, fwd_pending;
  logic [NF*3-1:0]  fwd_reg;
  logic [NF*16-1:0] fwd_data;
  logic [15:0] out_ir, out_op_a, out_op_b, out_rx, ldst_addr, ldst_wrdata;
  logic [CW-1:0] stall_count;

  logic        fv[NF];
  logic [2:0]  fr[NF];
  logic        fp[NF];
  logic [15:0] fd[NF];

  assign fwd_valid   = {fv[1], fv[0]};
  assign fwd_reg     = {fr[1], fr[0]};
  assign fwd_pending = {fp[1], fp[0]};
  assign fwd_data    = {fd[1], fd[0]};

  stage_operand_fetch #(.DATA_W(16), .REG_AW(3), .NUM_FWD(NF), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc_plus_2(in_pc_plus_2),
    .rf_sel_A(rf_sel_A), .rf_sel_B(rf_sel_B), .rf_A(rf_A), .rf_B(rf_B),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_pending(fwd_pending),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rx(out_rx),
    .ldst_addr(ldst_addr), .ldst_rd(ldst_rd), .ldst_wr(ldst_wr),
    .ldst_wrdata(ldst_wrdata), .stall_count(stall_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] a, b, rx, addr;
    logic        haz, is_ld, is_st;
  } exp_t;

  function automatic logic [15:0] pick(input logic [2:0] r, input logic [15:0] rf, output logic pend);
    pend = 1'b0;
    for (int i = 0; i < NF; i++)
      if (fv[i] && fr[i] == r) begin
        pend = fp[i];
        return fd[i];
      end
    return rf;
  endfunction

  function automatic exp_t model(input logic [15:0] ir, input logic [15:0] pc,
                                 input logic [15:0] ra, input logic [15:0] rb);
    exp_t e;
    logic px, py, imm;
    logic [15:0] x, y;
    int s8, s11, op;
    e = '{default: '0};
    x = pick(ir[7:5], ra, px);
    y = pick(ir[10:8], rb, py);
    op = int'(ir[3:0]);
    imm = ir[4];
    s8 = int'(ir[15:8]);
    if (s8 > 127) s8 -= 256;
    s11 = int'(ir[15:5]);
    if (s11 > 1023) s11 -= 2048;
    e.rx = x;
    case (op)
      0: begin e.b = imm ? 16'(s8) : y; e.haz = !imm && py; end
      1, 2, 3: begin e.a = x; e.b = imm ? 16'(s8) : y; e.haz = px || (!imm && py); end
      4: begin e.b = y; e.haz = py; e.addr = y & 16'hFFFE; e.is_ld = 1'b1; end
      5: begin e.b = y; e.haz = px || py; e.addr = y & 16'hFFFE; e.is_st = 1'b1; end
      6: begin e.a = x & 16'h00FF; e.b = 16'(ir[15:8]) << 8; e.haz = px; end
      8, 9, 10: begin
        e.a = imm ? pc : x;
        e.b = imm ? 16'(s11 * 2) : 16'h0000;
        e.haz = !imm && px;
      end
      12: e.b = pc;
      default: ;
    endcase
    return e;
  endfunction

  logic        m_valid = 1'b0, m_stall = 1'b0;
  logic [15:0] m_ir = '0, m_a = '0, m_b = '0, m_rx = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    exp_t e;
    logic adv, go, stalled;
    e = model(in_ir, in_pc_plus_2, rf_A, rf_B);
    adv = !m_valid || out_ready;
    go = in_valid && !e.haz && adv && !flush;
    stalled = e.haz && (in_valid || m_stall) && !flush;
    if (reset) begin
      m_valid = 1'b0; m_stall = 1'b0; m_cnt = 0;
      m_ir = '0; m_a = '0; m_b = '0; m_rx = '0;
    end else begin
      m_stall = stalled;
      if (stalled && m_cnt < (1 << CW) - 1) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (go) begin
        m_valid = 1'b1; m_ir = in_ir; m_a = e.a; m_b = e.b; m_rx = e.rx;
      end else if (out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      logic rdy, go;
      e = model(in_ir, in_pc_plus_2, rf_A, rf_B);
      rdy = !e.haz && (!m_valid || out_ready) && !flush;
      go = in_valid && rdy && !reset;
      check("in_ready", in_ready, rdy);
      check("ldst_rd", ldst_rd, go && e.is_ld);
      check("ldst_wr", ldst_wr, go && e.is_st);
      check("ldst_addr", ldst_addr, e.addr);
      check("ldst_wrdata", ldst_wrdata, e.rx);
      check("rf_sel_A", rf_sel_A, in_ir[7:5]);
      check("rf_sel_B", rf_sel_B, in_ir[10:8]);
      check("out_valid", out_valid, m_valid);
      check("out_ir", out_ir, m_ir);
      check("out_op_a", out_op_a, m_a);
      check("out_op_b", out_op_b, m_b);
      check("out_rx", out_rx, m_rx);
      check("stall_count", stall_count, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    for (int i = 0; i < NF; i++) begin
      fv[i] = 1'b0; fr[i] = '0; fp[i] = 1'b0; fd[i] = '0;
    end
  endtask

  logic [15:0] tbl_ir[6];
  initial begin
    tbl_ir = '{16'h8010, 16'hAB26, 16'h000C, 16'hF033, 16'h0007, 16'h0028};
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc_plus_2 = '0;
    rf_A = '0; rf_B = '0; flush = 1'b0; out_ready = 1'b1;
    no_fwd();
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_op_a", out_op_a, 0);
    check("rst_stall_count", stall_count, 0);

    // ADD R1,R2 straight from the register file
    in_valid = 1'b1; in_ir = 16'h0221; rf_A = 16'd5; rf_B = 16'd7;
    #1 check("add_sel_a", rf_sel_A, 1);
    check("add_sel_b", rf_sel_B, 2);
    cyc();
    check("add_op_a", out_op_a, 16'd5);
    check("add_op_b", out_op_b, 16'd7);
    check("add_valid", out_valid, 1);

    // both sources write R2: youngest wins
    fv = '{1'b1, 1'b1}; fr = '{3'd2, 3'd2}; fd = '{16'h1111, 16'h2222};
    cyc();
    check("fwd_prio_b", out_op_b, 16'h1111);
    check("fwd_prio_a", out_op_a, 16'd5);

    // LD R3,[R2] with a pending producer for two cycles
    no_fwd();
    in_ir = 16'h0264; fv[0] = 1'b1; fr[0] = 3'd2; fp[0] = 1'b1; fd[0] = 16'h1235;
    repeat (2) begin
      #1 check("lu_in_ready", in_ready, 0);
      check("lu_ldst_rd", ldst_rd, 0);
      cyc();
    end
    check("lu_stall_count", stall_count, 2);
    fp[0] = 1'b0;
    #1 check("lu_fire_rd", ldst_rd, 1);
    check("lu_fire_addr", ldst_addr, 16'h1234);
    cyc();

    // execute back-pressure: new ST word waits, output holds
    no_fwd();
    out_ready = 1'b0; in_ir = 16'h0225;
    repeat (3) begin
      #1 check("bp_in_ready", in_ready, 0);
      check("bp_ldst_wr", ldst_wr, 0);
      check("bp_out_ir", out_ir, 16'h0264);
      cyc();
    end
    out_ready = 1'b1;
    #1 check("bp_release_wr", ldst_wr, 1);
    cyc();
    check("bp_new_ir", out_ir, 16'h0225);

    // flush while stalled, with out_valid held by back-pressure
    out_ready = 1'b0;
    in_ir = 16'h0264; fv[0] = 1'b1; fr[0] = 3'd2; fp[0] = 1'b1; fd[0] = 16'h4444;
    cyc();
    flush = 1'b1;
    #1 check("fl_ldst_rd", ldst_rd, 0);
    cyc();
    check("fl_out_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check("fl_back_to_run", stall_count, 3);

    // JZ with an 11-bit immediate of all ones
    no_fwd();
    in_valid = 1'b1; in_ir = 16'hFFF9; in_pc_plus_2 = 16'h0100;
    cyc();
    check("jz_op_a", out_op_a, 16'h0100);
    check("jz_op_b", out_op_b, 16'hFFFE);

    // remaining opcode forms, checked by the model
    rf_A = 16'h1234; rf_B = 16'h00F0; in_pc_plus_2 = 16'h0200;
    foreach (tbl_ir[i]) begin
      in_ir = tbl_ir[i];
      cyc();
      if (i == 1) begin
        check("mvhi_op_a", out_op_a, 16'h0034);
        check("mvhi_op_b", out_op_b, 16'hAB00);
      end
    end

    // long stall saturates the narrow counter; output held by back-pressure
    out_ready = 1'b0;
    in_ir = 16'h0264; fv[0] = 1'b1; fr[0] = 3'd2; fp[0] = 1'b1; fd[0] = 16'h0F0F;
    repeat (9) cyc();
    check("sat_count", stall_count, 7);

    // reset in the middle of the stall
    reset = 1'b1; fp[0] = 1'b0; out_ready = 1'b1;
    #1 check("rst_ldst_rd", ldst_rd, 0);
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", stall_count, 0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_operand_fetch.md
Name: stage_operand_fetch

Overview:
- Parametrised successor of the register-read stage of the 16-bit pipelined CPU. Sits between fetch and execute.
- Decodes the fetched instruction word and drives the register-file read selects.
- Resolves operands through N-way priority forwarding and interlocks on load-use hazards. Builds ALU operands A/B and issues data-memory load/store requests.
- Holds a registered output stage with a valid/ready handshake toward execute, replacing the free-running valid flag.

Parameters:
- DATA_W, 16, datapath and instruction width (≥16).
- REG_AW, 3, register-select width (2^REG_AW registers).
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest (highest priority).
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  stage can accept the word this cycle.
- in_ir  in  DATA_W  instruction word.
- in_pc_plus_2  in  DATA_W  PC+2 of the instruction.
- rf_sel_A / rf_sel_B  out  REG_AW  Rx = ir[7:5], Ry = ir[10:8].
- rf_A / rf_B  in  DATA_W  register-file read data.
- fwd_valid  in  NUM_FWD  forwarding source i holds a writing instruction.
- fwd_reg  in  NUM_FWD*REG_AW  destination register of source i.
- fwd_pending  in  NUM_FWD  the result of source i is not yet available (load in flight).
- fwd_data  in  NUM_FWD*DATA_W  result of source i.
- flush  in  1  kill the word in this stage and the output register.
- out_valid  out  1  execute-side valid.
- out_ready  in  1  execute accepts.
- out_ir, out_op_a, out_op_b, out_rx  out  DATA_W  registered instruction, operands, and forwarded Rx (branch/jump target).
- ldst_addr  out  DATA_W  combinational; bit 0 forced to 0.
- ldst_rd, ldst_wr  out  1  combinational; high only in the fire cycle.
- ldst_wrdata  out  DATA_W  forwarded Rx.
- stall_count  out  STALL_CNT_W  number of hazard-stall cycles.

Behaviour:
- Reset: out_valid = 0; out_ir, out_op_a, out_op_b, out_rx = 0; stall_count = 0; FSM = RUN. ldst_rd and ldst_wr are 0 while reset is high.
- Forwarding, per source operand (Rx, Ry):
  - The operand uses the lowest index i with fwd_valid[i] && fwd_reg[i] == sel.
  - If no source matches, the operand uses rf_*.
- Hazard:
  - Raised when the matching source for an operand the opcode reads has fwd_pending = 1.
  - Operands read per opcode:
    - Rx read by ADD, SUB, CMP, MVHI, ST, and register jumps.
    - Ry read by the register forms of MV/ADD/SUB/CMP, and by LD/ST.
- advance = !out_valid || out_ready.
- fire = in_valid && !hazard && advance && !flush.
- in_ready = !hazard && advance && !flush.
- FSM RUN/STALL:
  - RUN→STALL when in_valid && hazard.
  - STALL→RUN when hazard clears, or on flush.
  - stall_count increments in each STALL cycle and saturates at all-ones.
- Output register:
  - On fire: load all fields; out_valid = 1.
  - Else if out_ready: out_valid = 0.
  - Else: hold all fields.
  - Flush: out_valid = 0 next cycle, regardless of fire or out_ready. Flush beats stall and fire in the same cycle.
- Operands (imm = ir[4]; sext8 = sign-extend ir[15:8]; sext11 = sign-extend ir[15:5]):
  - MV: a = 0; b = imm ? sext8 : Ry.
  - ADD/SUB/CMP: a = Rx; b = imm ? sext8 : Ry.
  - MVHI: a = Rx & 0x00FF; b = ir[15:8] << 8.
  - LD/ST: a = 0; b = Ry.
  - J/JZ/JN: a = imm ? pc_plus_2 : Rx; b = imm ? sext11 << 1 : 0.
  - CALL: a = 0; b = pc_plus_2.
  - Any other opcode: a = b = 0.
- Load/store:
  - LD: ldst_rd = fire; ldst_addr = {Ry[DATA_W-1:1], 0}.
  - ST: ldst_wr = fire, with the same address.
  - Otherwise ldst_rd/ldst_wr = 0 and ldst_addr = 0.
  - A memory request is never issued for a stalled or flushed word.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: OP_MV = 0, OP_ADD = 1, OP_SUB = 2, OP_CMP = 3, OP_LD = 4, OP_ST = 5, OP_MVHI = 6, OP_J = 8, OP_JZ = 9, OP_JN = 10, OP_CALL = 12.
  - Field-slice localparams.
  - FSM enum stall_state_t.
- Sub-module fwd_select: parametrised priority mux producing data, hit, and pending. Instantiated twice, once per operand.

Test Plan:
- ADD R1,R2 with rf_A = 5, rf_B = 7, no forwarding → next cycle out_op_a = 5, out_op_b = 7, out_valid = 1.
- Both fwd sources hit R2 (src0 = 0x1111, src1 = 0x2222) → out_op_b = 0x1111.
- LD R3,[R2] with src0 hitting R2 and fwd_pending = 1 for 2 cycles:
  - in_ready = 0 and ldst_rd = 0 for 2 cycles; stall_count = 2.
  - Third cycle: ldst_rd = 1 and ldst_addr = forwarded value & 0xFFFE.
- out_ready = 0 for 3 cycles with a new in_valid word → out_* held, in_ready = 0, no ldst strobes.
- flush asserted during STALL together with in_valid → out_valid = 0 next cycle, FSM = RUN, no ldst strobe.
- JZ imm, ir[15:5] = 0x7FF, pc_plus_2 = 0x0100 → out_op_a = 0x0100, out_op_b = 0xFFFE.
- Hold reset mid-stall → out_valid = 0 and stall_count = 0 the following cycle.
